pipe_hazard_ctrl: RTL and testbench

- Central sequencer for the 5-stage pipeline around the execute stage. It detects load-use hazards, sequences taken-branch/jump flush bubbles, and freezes the pipe while memory is not ready.
- It drives the execute stage `stall` input, the upstream hold, the bubble injected into execute `v_in`, and the fetch PC redirect select.
- It also keeps saturating performance counters for stalls and redirects.

---
 rtl/rv_pkg.sv | 31 +++
 rtl/hazard_detect.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 decode constants, hazard controller state encodings and register-use helpers.
// No timing of its own; constants and pure functions only.
// No flow control.
package rv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_LU       = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;
    localparam logic [1:0] ST_MEM_WAIT = 2'd3;

    // The argument is the 7-bit opcode field of the instruction (ir[6:0]).
    // Only U-type and JAL have no rs1 field.
    function automatic logic uses_rs1(input logic [6:0] ir);
        return (ir != OP_LUI) && (ir != OP_AUIPC) && (ir != OP_JAL);
    endfunction

    // Only R, S and B formats read rs2.
    function automatic logic uses_rs2(input logic [6:0] ir);
        return (ir == OP_R) || (ir == OP_STORE) || (ir == OP_BRANCH);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: a load in execute whose rd is read by the instruction in decode.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is consumed by the hazard sequencer.
// Ports: id_ir/id_valid (decode instruction), ex_ir/ex_valid (execute output), lu (hazard).
module hazard_detect
    import rv_pkg::*;
(
    input  logic [31:0] id_ir,
    input  logic        id_valid,
    input  logic [31:0] ex_ir,
    input  logic        ex_valid,
    output logic        lu
);

    logic [4:0] ld_rd;
    logic       ex_is_load;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       unused_bits;

    assign ld_rd      = ex_ir[11:7];
    assign ex_is_load = ex_valid && (ex_ir[6:0] == OP_LOAD) && (ld_rd != 5'd0);
    assign rs1_hit    = uses_rs1(id_ir[6:0]) && (id_ir[19:15] == ld_rd);
    assign rs2_hit    = uses_rs2(id_ir[6:0]) && (id_ir[24:20] == ld_rd);
    assign lu         = ex_is_load && id_valid && (rs1_hit || rs2_hit);

    // Immediate/funct fields play no part in the hazard decision.
    assign unused_bits = ^{ex_ir[31:12], id_ir[31:25], id_ir[14:7]};

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: load-use bubbles, taken-branch flush, memory-not-ready freeze.
// Latency: control outputs are Mealy (same cycle as inputs); state/counters update on clk rise.
// Backpressure: !mem_ready freezes execute and later (stall) and fetch/decode (hold_id).
// Ports: id_*/ex_* pipeline taps, mem_ready; stall/hold_id/bubble_ex/flush/redirect controls,
//        state_o debug, stall_cnt/flush_cnt saturating performance counters.
module pipe_hazard_ctrl
    import rv_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_ir,
    input  logic             id_valid,
    input  logic [31:0]      ex_ir,
    input  logic             ex_valid,
    input  logic             ex_taken,
    input  logic             mem_ready,
    output logic             stall,
    output logic             hold_id,
    output logic             bubble_ex,
    output logic             flush,
    output logic             redirect,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Flush cycles remaining after the redirect cycle itself.
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic             pend_q, pend_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             lu;
    logic             s_c, h_c, b_c, f_c, r_c;
    logic             take_redir;

    hazard_detect u_hazard_detect (
        .id_ir    (id_ir),
        .id_valid (id_valid),
        .ex_ir    (ex_ir),
        .ex_valid (ex_valid),
        .lu       (lu)
    );

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        fcnt_d     = fcnt_q;
        s_c        = 1'b0;
        h_c        = 1'b0;
        b_c        = 1'b0;
        f_c        = 1'b0;
        r_c        = 1'b0;
        take_redir = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!mem_ready) begin
                    s_c     = 1'b1;
                    h_c     = 1'b1;
                    state_d = ST_MEM_WAIT;
                    pend_d  = ex_valid & ex_taken;
                end else if (ex_valid && ex_taken) begin
                    // A coincident load-use is dropped: decode is being flushed.
                    take_redir = 1'b1;
                end else if (lu) begin
                    h_c     = 1'b1;
                    b_c     = 1'b1;
                    state_d = ST_LU;
                end
            end
            ST_LU: begin
                // ex_ir still shows the load while execute carries the bubble,
                // so hazard detection must not fire again here.
                if (!mem_ready) begin
                    s_c     = 1'b1;
                    h_c     = 1'b1;
                    state_d = ST_MEM_WAIT;
                    pend_d  = 1'b0;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                f_c = 1'b1;
                if (!mem_ready) begin
                    s_c = 1'b1;
                    h_c = 1'b1;
                end else if (fcnt_q <= 4'd1) begin
                    fcnt_d  = 4'd0;
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ready) begin
                    s_c    = 1'b1;
                    h_c    = 1'b1;
                    pend_d = pend_q | ex_taken;
                end else if (pend_q) begin
                    pend_d     = 1'b0;
                    take_redir = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (take_redir) begin
            r_c     = 1'b1;
            f_c     = 1'b1;
            fcnt_d  = FLUSH_INIT;
            state_d = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pend_q      <= 1'b0;
            fcnt_q      <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            fcnt_q  <= fcnt_d;
            if ((s_c || h_c) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (r_c && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    // Inputs can be live during reset; keep the pipe controls quiet then.
    assign stall     = rst_n & s_c;
    assign hold_id   = rst_n & h_c;
    assign bubble_ex = rst_n & b_c;
    assign flush     = rst_n & f_c;
    assign redirect  = rst_n & r_c;
    assign state_o   = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_ir, ex_ir;
    logic        id_valid, ex_valid, ex_taken, mem_ready;

    logic        a_stall, a_hold, a_bub, a_flush, a_redir;
    logic [1:0]  a_state;
    logic [15:0] a_scnt, a_fcnt;
    logic        b_stall, b_hold, b_bub, b_flush, b_redir;
    logic [1:0]  b_state;
    logic [1:0]  b_scnt, b_fcnt;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] LW_X5       = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
    localparam logic [31:0] LW_X0       = {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011};
    localparam logic [31:0] ADD_X6_5_2  = {7'd0, 5'd2, 5'd5, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] ADD_X6_0_0  = {7'd0, 5'd0, 5'd0, 3'd0, 5'd6, 7'b0110011};
    localparam logic [31:0] LUI_X6_R5   = {12'd0, 5'd5, 3'd0, 5'd6, 7'b0110111};
    localparam logic [31:0] NOP         = 32'h0000_0013;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_ir(id_ir), .id_valid(id_valid),
        .ex_ir(ex_ir), .ex_valid(ex_valid), .ex_taken(ex_taken), .mem_ready(mem_ready),
        .stall(a_stall), .hold_id(a_hold), .bubble_ex(a_bub), .flush(a_flush),
        .redirect(a_redir), .state_o(a_state), .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
    );

    pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_ir(id_ir), .id_valid(id_valid),
        .ex_ir(ex_ir), .ex_valid(ex_valid), .ex_taken(ex_taken), .mem_ready(mem_ready),
        .stall(b_stall), .hold_id(b_hold), .bubble_ex(b_bub), .flush(b_flush),
        .redirect(b_redir), .state_o(b_state), .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
    );

    // Reference model, one slot per DUT instance.
    int fc_cfg [2] = '{2, 1};
    int mx_cfg [2] = '{65535, 3};
    int flush_left [2];   // flush cycles still owed after the current one
    bit in_wait    [2];   // frozen waiting for memory
    bit pend       [2];   // redirect remembered during the freeze
    bit after_lu   [2];   // the cycle right after a load-use bubble
    int n_stall    [2];
    int n_redir    [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            flush_left[k] = 0; in_wait[k] = 0; pend[k] = 0; after_lu[k] = 0;
            n_stall[k] = 0; n_redir[k] = 0;
        end
    endtask

    function automatic bit model_lu();
        logic [6:0] eo, io;
        logic [4:0] rd;
        eo = ex_ir[6:0];
        io = id_ir[6:0];
        rd = ex_ir[11:7];
        if (!(ex_valid && id_valid && eo == 7'b0000011 && rd != 5'd0)) return 1'b0;
        if (io != 7'b0110111 && io != 7'b0010111 && io != 7'b1101111 && id_ir[19:15] == rd)
            return 1'b1;
        if ((io == 7'b0110011 || io == 7'b0100011 || io == 7'b1100011) && id_ir[24:20] == rd)
            return 1'b1;
        return 1'b0;
    endfunction

    // Produces this cycle's expected controls {stall,hold,bubble,flush,redirect,state}
    // and advances the model to its post-edge condition.
    task automatic model_step(input int k, output logic [6:0] ctl);
        bit s, h, b, f, r;
        logic [1:0] st;
        s = 0; h = 0; b = 0; f = 0; r = 0;
        st = in_wait[k] ? 2'd3 : (flush_left[k] > 0) ? 2'd2 : after_lu[k] ? 2'd1 : 2'd0;
        if (in_wait[k]) begin
            if (!mem_ready) begin
                s = 1; h = 1; pend[k] = pend[k] | ex_taken;
            end else begin
                if (pend[k]) begin
                    r = 1; f = 1; flush_left[k] = fc_cfg[k] - 1; pend[k] = 0;
                end
                in_wait[k] = 0;
            end
        end else if (flush_left[k] > 0) begin
            f = 1;
            if (!mem_ready) begin s = 1; h = 1; end
            else flush_left[k] = flush_left[k] - 1;
        end else if (after_lu[k]) begin
            after_lu[k] = 0;
            if (!mem_ready) begin s = 1; h = 1; in_wait[k] = 1; pend[k] = 0; end
        end else begin
            if (!mem_ready) begin
                s = 1; h = 1; in_wait[k] = 1; pend[k] = ex_valid && ex_taken;
            end else if (ex_valid && ex_taken) begin
                r = 1; f = 1; flush_left[k] = fc_cfg[k] - 1;
            end else if (model_lu()) begin
                h = 1; b = 1; after_lu[k] = 1;
            end
        end
        if (s || h) n_stall[k]++;
        if (r) n_redir[k]++;
        ctl = {s, h, b, f, r, st};
    endtask

    function automatic logic [31:0] sat(input int v, input int mx);
        return (v > mx) ? 32'(mx) : 32'(v);
    endfunction

    function automatic logic [6:0] dut_ctl(input int k);
        return (k == 0) ? {a_stall, a_hold, a_bub, a_flush, a_redir, a_state}
                        : {b_stall, b_hold, b_bub, b_flush, b_redir, b_state};
    endfunction

    // Called just after a falling edge with inputs already applied; returns at the next one.
    task automatic run_cycle();
        logic [6:0] e;
        #2;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("stall_cnt%0d", k), (k == 0) ? 32'(a_scnt) : 32'(b_scnt),
                sat(n_stall[k], mx_cfg[k]));
            chk($sformatf("flush_cnt%0d", k), (k == 0) ? 32'(a_fcnt) : 32'(b_fcnt),
                sat(n_redir[k], mx_cfg[k]));
            model_step(k, e);
            chk($sformatf("ctl%0d", k), 32'(dut_ctl(k)), 32'(e));
        end
        @(negedge clk);
    endtask

    task automatic set_in(input logic [31:0] iid, input logic iv, input logic [31:0] iex,
                          input logic ev, input logic tk, input logic mr);
        id_ir = iid; id_valid = iv; ex_ir = iex; ex_valid = ev; ex_taken = tk; mem_ready = mr;
    endtask

    logic [6:0] ops [8] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0110111,
                            7'b0010111, 7'b1101111, 7'b0000011, 7'b0010011};

    initial begin
        rst_n = 1'b0;
        set_in(ADD_X6_5_2, 1, LW_X5, 1, 1, 0);
        model_reset();
        #3;
        chk("rst_ctl_a", 32'({a_stall, a_hold, a_bub, a_flush, a_redir}), 32'd0);
        chk("rst_state_a", 32'(a_state), 32'd0);
        chk("rst_cnt_a", 32'({a_scnt, a_fcnt}), 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_ctl_b", 32'({b_stall, b_hold, b_bub, b_flush, b_redir}), 32'd0);
        rst_n = 1'b1;

        // Load-use: bubble then one quiet LU cycle.
        set_in(ADD_X6_5_2, 1, LW_X5, 1, 0, 1);
        #1;
        chk("lu_hold_bub", 32'({a_stall, a_hold, a_bub}), 32'b011);
        run_cycle();
        #1;
        chk("lu_state", 32'(a_state), 32'd1);
        chk("lu_quiet", 32'({a_stall, a_hold, a_bub, a_flush, a_redir}), 32'd0);
        run_cycle();
        set_in(NOP, 1, NOP, 1, 0, 1);
        #1;
        chk("lu_back_run", 32'(a_state), 32'd0);
        chk("lu_stall_cnt", 32'(a_scnt), 32'd1);
        run_cycle();

        // No hazard: load to x0, and LUI whose rs1-position bits match rd.
        set_in(ADD_X6_0_0, 1, LW_X0, 1, 0, 1);
        #1;
        chk("x0_nohaz", 32'({a_hold, a_bub}), 32'd0);
        run_cycle();
        set_in(LUI_X6_R5, 1, LW_X5, 1, 0, 1);
        #1;
        chk("lui_nohaz", 32'({a_hold, a_bub}), 32'd0);
        run_cycle();

        // Taken branch with a coincident load-use that must be dropped.
        set_in(ADD_X6_5_2, 1, LW_X5, 1, 1, 1);
        #1;
        chk("br_redir", 32'({a_redir, a_flush, a_hold, a_bub}), 32'b1100);
        run_cycle();
        #1;
        chk("br_flush2", 32'({a_redir, a_flush}), 32'b01);
        chk("br_fcnt", 32'(a_fcnt), 32'd1);
        run_cycle();
        set_in(NOP, 1, NOP, 1, 0, 1);
        #1;
        chk("br_done", 32'({a_state, a_flush, a_redir}), 32'd0);
        run_cycle();

        // Three memory-wait cycles with a taken branch on the second.
        set_in(NOP, 1, NOP, 1, 0, 0);
        #1; chk("mw1", 32'({a_stall, a_hold}), 32'b11);
        run_cycle();
        ex_taken = 1;
        #1; chk("mw2", 32'({a_stall, a_hold, a_state}), 32'b1111);
        run_cycle();
        ex_taken = 0;
        #1; chk("mw3", 32'({a_stall, a_hold}), 32'b11);
        run_cycle();
        mem_ready = 1;
        #1;
        chk("mw_redir", 32'({a_redir, a_flush, a_stall, a_hold}), 32'b1100);
        chk("mw_scnt", 32'(a_scnt), 32'd4);
        run_cycle();
        #1;
        chk("mw_flush2", 32'({a_redir, a_flush}), 32'b01);
        chk("mw_fcnt", 32'(a_fcnt), 32'd2);
        run_cycle();
        #1; chk("mw_done", 32'(a_state), 32'd0);
        run_cycle();

        // Reset in the middle of a flush.
        ex_taken = 1;
        run_cycle();
        ex_taken = 0;
        #1;
        chk("pre_rst_flush", 32'({a_flush, a_state}), 32'b110);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", 32'({a_stall, a_hold, a_bub, a_flush, a_redir}), 32'd0);
        chk("mid_rst_state", 32'(a_state), 32'd0);
        chk("mid_rst_cnt", 32'({a_scnt, a_fcnt, b_scnt, b_fcnt}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Five back-to-back redirects on the 2-bit counter instance.
        set_in(NOP, 1, NOP, 1, 1, 1);
        repeat (5) run_cycle();
        ex_taken = 0;
        #1;
        chk("sat_fcnt_b", 32'(b_fcnt), 32'd3);
        repeat (2) run_cycle();

        // Randomized traffic biased toward hazards, branches and memory stalls.
        repeat (3000) begin
            logic [31:0] ex_v, id_v;
            int sel;
            sel = $urandom_range(0, 3);
            if (sel <= 1)
                ex_v = {12'($urandom), 5'($urandom_range(0, 3)), 3'b010,
                        5'($urandom_range(0, 3)), 7'b0000011};
            else if (sel == 2)
                ex_v = {25'($urandom), 7'b1100011};
            else
                ex_v = 32'($urandom);
            id_v = {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    3'($urandom), 5'($urandom), ops[$urandom_range(0, 7)]};
            set_in(id_v, $urandom_range(0, 9) != 0, ex_v, $urandom_range(0, 9) != 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0);
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
